// File: rtl/fpu_operand_loader_if.sv
// Signal bundle between the byte-serial operand loader and its surroundings:
// the upstream byte stream, the FPU operand/result wires and the result outputs.
interface fpu_operand_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] op_A_out;
    logic [31:0] op_B_out;
    logic [31:0] fpu_data_in;
    logic [3:0]  fpu_status_in;
    logic [31:0] result_out;
    logic [3:0]  status_out;
    logic        status_err;
    logic        result_valid;
    logic        busy;

    // Environment side: byte source and FPU outputs.
    modport master (
        output byte_in,
        output byte_valid,
        output fpu_data_in,
        output fpu_status_in,
        input  byte_ready,
        input  op_A_out,
        input  op_B_out,
        input  result_out,
        input  status_out,
        input  status_err,
        input  result_valid,
        input  busy
    );

    // Loader side.
    modport slave (
        input  byte_in,
        input  byte_valid,
        input  fpu_data_in,
        input  fpu_status_in,
        output byte_ready,
        output op_A_out,
        output op_B_out,
        output result_out,
        output status_out,
        output status_err,
        output result_valid,
        output busy
    );
endinterface

// File: rtl/fpu_operand_loader.sv
// Assembles two big-endian 32-bit operands from a byte stream, holds them on the
// FPU inputs for HOLD_CYCLES cycles, then captures the FPU result and status.
module fpu_operand_loader #(
    parameter int HOLD_CYCLES = 80
) (
    input  logic                 clock100KHz,
    input  logic                 reset,
    fpu_operand_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        APPLY   = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [2:0]  index_reg;
    logic [7:0]  count_reg;
    logic [63:0] shadow_bus;
    logic [31:0] op_a_reg;
    logic [31:0] op_b_reg;
    logic [31:0] result_reg;
    logic [3:0]  status_reg;
    logic        status_err_reg;
    logic        result_valid_reg;
    logic        status_err_next;

    logic        byte_ready_int;
    logic        busy_int;
    logic        load_ops;
    logic        capture;
    logic        accept;

    assign accept = bus.byte_valid && byte_ready_int;

    // State register.
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            state_reg <= LOAD_A;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD_A:  if (accept && index_reg == 3'd3) state_next = LOAD_B;
            LOAD_B:  if (accept && index_reg == 3'd7) state_next = APPLY;
            APPLY:   state_next = WAIT;
            WAIT:    if (count_reg == 8'd0) state_next = CAPTURE;
            CAPTURE: state_next = LOAD_A;
            default: state_next = LOAD_A;
        endcase
    end

    // Output decode, purely from state.
    always_comb begin
        byte_ready_int = 1'b0;
        busy_int       = 1'b0;
        load_ops       = 1'b0;
        capture        = 1'b0;
        case (state_reg)
            LOAD_A, LOAD_B: byte_ready_int = 1'b1;
            APPLY: begin
                busy_int = 1'b1;
                load_ops = 1'b1;
            end
            WAIT:  busy_int = 1'b1;
            CAPTURE: begin
                busy_int = 1'b1;
                capture  = 1'b1;
            end
            default: begin
                byte_ready_int = 1'b0;
                busy_int       = 1'b0;
            end
        endcase
    end

    // Byte index wraps 7 -> 0 naturally, ready for the next pair.
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            index_reg <= 3'd0;
        end else if (accept) begin
            index_reg <= index_reg + 3'd1;
        end
    end

    // One shadow byte lane per index; lane 0 is the MSB of operand A.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clock100KHz or negedge reset) begin
                if (!reset) begin
                    lane_reg <= 8'd0;
                end else if (accept && index_reg == 3'(gi)) begin
                    lane_reg <= bus.byte_in;
                end
            end

            assign shadow_bus[63 - 8*gi -: 8] = lane_reg;
        end
    endgenerate

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            op_a_reg <= 32'd0;
            op_b_reg <= 32'd0;
        end else if (load_ops) begin
            op_a_reg <= shadow_bus[63:32];
            op_b_reg <= shadow_bus[31:0];
        end
    end

    // Counter parks at zero outside WAIT so the reset value stays meaningful.
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            count_reg <= 8'd0;
        end else if (load_ops) begin
            count_reg <= 8'(HOLD_CYCLES - 1);
        end else if (state_reg == WAIT && count_reg != 8'd0) begin
            count_reg <= count_reg - 8'd1;
        end
    end

    assign status_err_next = !((bus.fpu_status_in != 4'd0) &&
                               ((bus.fpu_status_in & (bus.fpu_status_in - 4'd1)) == 4'd0));

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            result_reg       <= 32'd0;
            status_reg       <= 4'd0;
            status_err_reg   <= 1'b0;
            result_valid_reg <= 1'b0;
        end else begin
            result_valid_reg <= capture;
            if (capture) begin
                result_reg     <= bus.fpu_data_in;
                status_reg     <= bus.fpu_status_in;
                status_err_reg <= status_err_next;
            end
        end
    end

    assign bus.byte_ready   = byte_ready_int;
    assign bus.busy         = busy_int;
    assign bus.op_A_out     = op_a_reg;
    assign bus.op_B_out     = op_b_reg;
    assign bus.result_out   = result_reg;
    assign bus.status_out   = status_reg;
    assign bus.status_err   = status_err_reg;
    assign bus.result_valid = result_valid_reg;

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Directed bench for fpu_operand_loader: a vector table of operand pairs with a
// stand-in FPU result, plus hand-written reset sequences.
module tb_fpu_operand_loader;

    localparam int HOLD = 80;

    typedef struct {
        logic [63:0] bytes;
        logic [31:0] fpu_data;
        logic [3:0]  fpu_status;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_err;
        bit          gappy;
        bit          hold_in_wait;
    } vec_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   pulses;
    int   double_pulses;
    int   completed;
    logic prev_rv;

    fpu_operand_loader_if bus ();

    fpu_operand_loader #(.HOLD_CYCLES(HOLD)) dut (
        .clock100KHz (clk),
        .reset       (reset),
        .bus         (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        prev_rv       = 1'b0;
        pulses        = 0;
        double_pulses = 0;
    end

    always @(negedge clk) begin
        if (bus.result_valid) begin
            pulses = pulses + 1;
            if (prev_rv) double_pulses = double_pulses + 1;
        end
        prev_rv = bus.result_valid;
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic check_reset_values(input string name);
        check(name, {bus.op_A_out, bus.op_B_out}, 64'd0);
        check({name, "_res"}, {bus.result_out, 4'd0, bus.status_out, 3'd0, bus.status_err,
                              3'd0, bus.result_valid, 3'd0, bus.byte_ready, 3'd0, bus.busy},
              {32'd0, 4'd0, 4'd0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0});
    endtask

    task automatic send_byte(input logic [7:0] b, input bit expect_immediate);
        int n;
        n = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (!bus.byte_ready && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) check("byte_timeout", 64'(n), 64'd0);
        if (expect_immediate) check("b2b_accept_wait", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    // Returns in the cycle where result_valid should be high.
    task automatic run_pair(input vec_t v, input bit b2b,
                            input logic [31:0] prev_res, input logic [31:0] prev_a);
        int bad;
        for (int i = 0; i < 8; i++) begin
            send_byte(v.bytes[63 - 8*i -: 8], b2b && (i == 0));
            if (v.gappy && i < 7) begin
                @(posedge clk);
                #1;
            end
        end
        check("op_hold_during_load", {32'd0, bus.op_A_out}, {32'd0, prev_a});
        check("result_hold", {32'd0, bus.result_out}, {32'd0, prev_res});
        check("apply_busy", {63'd0, bus.busy}, 64'd1);
        bus.fpu_data_in   = ~v.fpu_data;
        bus.fpu_status_in = ~v.fpu_status;
        @(posedge clk);
        #1;
        check("operands", {bus.op_A_out, bus.op_B_out}, {v.exp_a, v.exp_b});
        if (v.hold_in_wait) begin
            bus.byte_in    = 8'hAA;
            bus.byte_valid = 1'b1;
        end
        bad = 0;
        for (int k = 2; k <= HOLD + 1; k++) begin
            @(posedge clk);
            #1;
            if (bus.result_valid || bus.byte_ready || !bus.busy) bad++;
        end
        check("wait_window", 64'(bad), 64'd0);
        bus.byte_valid    = 1'b0;
        bus.fpu_data_in   = v.fpu_data;
        bus.fpu_status_in = v.fpu_status;
        @(posedge clk);
        #1;
        check("result_valid", {63'd0, bus.result_valid}, 64'd1);
        check("result", {28'd0, bus.status_out, bus.result_out}, {28'd0, v.fpu_status, v.fpu_data});
        check("status_err", {63'd0, bus.status_err}, {63'd0, v.exp_err});
        check("ready_after_capture", {62'd0, bus.byte_ready, bus.busy}, 64'd2);
        $display("[TB] pair A=%h B=%h result=%h status=%b err=%b", bus.op_A_out, bus.op_B_out,
                 bus.result_out, bus.status_out, bus.status_err);
        bus.fpu_data_in   = 32'h5A5A5A5A;
        bus.fpu_status_in = 4'b1010;
        completed++;
    endtask

    vec_t vecs[7];
    vec_t rv;

    initial begin
        int p0;
        logic [31:0] prev_res;
        logic [31:0] prev_a;

        tests     = 0;
        fails     = 0;
        completed = 0;
        vecs[0] = '{64'h40000000_40000000, 32'h42000000, 4'b0001, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{64'h40000000_C0000000, 32'h00000000, 4'b0001, 32'h40000000, 32'hC0000000, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{64'h12345678_9ABCDEF0, 32'hDEADBEEF, 4'b0010, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{64'h3F800000_00000001, 32'h3F800001, 4'b0110, 32'h3F800000, 32'h00000001, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{64'h7FFFFFFF_01020304, 32'h7FFFFFFF, 4'b0100, 32'h7FFFFFFF, 32'h01020304, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{64'hA5A5A5A5_5A5A5A5A, 32'h00000001, 4'b0000, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{64'hFEDCBA98_76543210, 32'h80000000, 4'b1111, 32'hFEDCBA98, 32'h76543210, 1'b1, 1'b0, 1'b0};
        rv      = '{64'h11223344_55667788, 32'hCAFEF00D, 4'b1000, 32'h11223344, 32'h55667788, 1'b0, 1'b0, 1'b0};

        reset             = 1'b0;
        bus.byte_in       = 8'd0;
        bus.byte_valid    = 1'b0;
        bus.fpu_data_in   = 32'd0;
        bus.fpu_status_in = 4'd0;
        #22;
        check_reset_values("reset_state");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        prev_res = 32'd0;
        prev_a   = 32'd0;
        for (int i = 0; i < 7; i++) begin
            run_pair(vecs[i], i > 0, prev_res, prev_a);
            prev_res = vecs[i].fpu_data;
            prev_a   = vecs[i].exp_a;
        end

        // Reset after five bytes of a new pair: partial bytes must not leak.
        send_byte(8'hFF, 1'b1);
        send_byte(8'hEE, 1'b0);
        send_byte(8'hDD, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hBB, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("reset_mid_load");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_pair(rv, 1'b0, 32'd0, 32'd0);

        // Reset during WAIT: the pending result must never be flagged.
        for (int i = 0; i < 8; i++) send_byte(vecs[2].bytes[63 - 8*i -: 8], 1'b0);
        repeat (20) @(posedge clk);
        #2;
        reset = 1'b0;
        p0 = pulses;
        #1;
        check_reset_values("reset_in_wait");
        @(negedge clk);
        reset = 1'b1;
        repeat (HOLD + 10) @(posedge clk);
        #1;
        check("no_pulse_after_reset", 64'(pulses), 64'(p0));
        check("result_cleared", {32'd0, bus.result_out}, 64'd0);

        check("pulse_count", 64'(pulses), 64'(completed));
        check("double_pulse", 64'(double_pulses), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
